shift_arbiter_ctrl: RTL
=======================

// Module: shift_arbiter_ctrl
// PURPOSE
//  Shares one 32-bit left-barrel-shifter datapath (5 mux layers: 1/2/4/8/16) between two requesters.
//  Arbitrates round-robin and derives SRL/SRA from the SLL core via bit-reversal plus a sign-fill mask.
//  Returns results through a single-entry registered response stage with valid/ready backpressure.
//  Sits between the integer issue port (req0) and the address/immediate generator (req1) of the core.
// PARAMETERS
//  START_PRI  0   requester that wins the first tie after reset (0 or 1)
//  DATA_W     32  datapath width; only 32 supported (shift amount is fixed 5 bits)
// PORTS
//  clk         in   1   single clock, all state on rising edge
//  rst         in   1   synchronous, active-high reset
//  req0_valid  in   1   requester 0 has an operation
//  req0_ready  out  1   requester 0 operation accepted this cycle (valid&ready)
//  req0_a      in   32  operand to shift
//  req0_b      in   5   shift amount
//  req0_op     in   2   00 SLL, 01 SRL, 11 SRA, 10 reserved (executes as SLL)
//  req1_valid/req1_ready/req1_a/req1_b/req1_op   same as req0 for requester 1
//  rsp_valid   out  1   response register holds a result
//  rsp_ready   in   1   consumer takes result this cycle
//  rsp_id      out  1   requester that issued the held result
//  rsp_s       out  32  shift result
// BEHAVIOUR
//  - Reset: rsp_valid=0, rsp_s=0, rsp_id=0, req0_ready=req1_ready=0 while rst high,
//    rr pointer set so START_PRI wins first tie; any held result is discarded.
//  - Response FSM: EMPTY (rsp_valid=0) / FULL (rsp_valid=1).
//    can_accept = EMPTY | (FULL & rsp_ready)  (pass-through drain+refill in same cycle).
//    EMPTY->FULL on accept; FULL->EMPTY on rsp_ready & no accept; FULL->FULL on drain+accept or stall.
//  - Arbitration (combinational, from current valids): one valid -> it is granted;
//    both valid -> requester != last_served. reqN_ready = grantN & can_accept; never both high.
//    last_served updates only on an accepted transfer; idle cycles keep it.
//  - Datapath (exactly one shifter instance, 5 layers as above):
//    SLL: s = a << b.  SRL: s = rev(rev(a) << b).  SRA: SRL result | (a[31] ? fill : 0),
//    fill = top b bits set, from a thermometer decode of b (no second shifter).
//    b=0 -> s=a for all ops. Bits shifted out are lost; no flags.
//  - Latency: accepted at edge N -> rsp_valid/rsp_s/rsp_id valid after edge N (1 cycle).
//    Throughput 1 result/cycle when rsp_ready held high.
//  - Stall: while FULL & !rsp_ready, rsp_s/rsp_id/rsp_valid hold stable, both readys 0.
//  - Request operands sampled only on the accept edge; changes while not ready are ignored.
//  - Reset mid-operation: held result dropped, rsp_valid=0 next cycle, arbitration restarts.
// TESTING
//  1. req0 SLL a=0x0000_0001 b=31, rsp_ready=1 -> next cycle rsp_valid=1, rsp_s=0x8000_0000, rsp_id=0.
//  2. req1 a=0x8000_0000 b=4: SRL -> 0x0800_0000; SRA -> 0xF800_0000; SRA b=0 -> 0x8000_0000;
//     op=10 with a=0x0000_00FF b=8 -> 0x0000_FF00.
//  3. Both valid every cycle, rsp_ready=1, START_PRI=0 -> rsp_id sequence 0,1,0,1; one rsp/cycle.
//  4. rsp held FULL (SRL 0xF000_0000 b=28 -> 0x0000_000F) with rsp_ready=0 for 3 cycles -> rsp_s
//     stable, req0_ready=req1_ready=0; rsp_ready=1 -> drain and accept a new op in the same cycle.
//  5. rst asserted while FULL and both requesting -> next cycle rsp_valid=0, readys 0; after release
//     first tie granted to START_PRI.
//  6. Only req1 valid for 4 ops, then both -> req1 served 4 times back-to-back, then req0 wins tie.

Source files
------------

// File: rtl/shift_arbiter_ctrl.sv
// shift_arbiter_ctrl: two requesters share one 32-bit left barrel shifter.
// Round-robin arbitration picks a requester. SRL and SRA are built on the same
// left-shift core by reversing the bits before and after the shift, and SRA
// adds a sign-fill mask. Each result goes into a single-entry response
// register that uses valid/ready handshaking.
module shift_arbiter_ctrl #(
    parameter int START_PRI = 0,
    parameter int DATA_W    = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [4:0]  req0_b,
    input  logic [1:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [4:0]  req1_b,
    input  logic [1:0]  req1_op,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_s
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } rsp_state_e;

    // After reset, last_served points away from START_PRI, so START_PRI wins the first tie.
    localparam logic LAST_INIT = (START_PRI == 0) ? 1'b1 : 1'b0;

    rsp_state_e  state_q, state_d;
    logic        last_q, last_d;
    logic        id_q, id_d;
    logic [31:0] s_q, s_d;

    logic        can_accept_s;
    logic        grant0_s, grant1_s, accept_s;
    logic [31:0] op_a_s, sh_in_s, sh_out_s, result_s;
    logic [4:0]  op_b_s;
    logic [1:0]  op_code_s;

    // Bit reversal. SRL and SRA use it around the left-shift core.
    function automatic logic [31:0] rev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31 - i];
        end
        return r;
    endfunction

    // Five-layer left barrel shifter with stages of 1, 2, 4, 8 and 16 bits.
    function automatic logic [31:0] shl32(input logic [31:0] v, input logic [4:0] amt);
        logic [31:0] l0, l1, l2, l3, l4;
        l0 = amt[0] ? {v[30:0],  1'b0}  : v;
        l1 = amt[1] ? {l0[29:0], 2'b00} : l0;
        l2 = amt[2] ? {l1[27:0], 4'h0}  : l1;
        l3 = amt[3] ? {l2[23:0], 8'h00} : l2;
        l4 = amt[4] ? {l3[15:0], 16'h0000} : l3;
        return l4;
    endfunction

    // Thermometer decode: sets the top amt bits. Bit i is set when i >= 32 - amt.
    function automatic logic [31:0] fill32(input logic [4:0] amt);
        logic [31:0] f;
        for (int i = 0; i < 32; i++) begin
            f[i] = (6'(31 - i) < {1'b0, amt});
        end
        return f;
    endfunction

    // Arbitration and handshake. Reset holds both readys low.
    always_comb begin
        can_accept_s = (state_q == ST_EMPTY) || rsp_ready;
        grant0_s     = req0_valid && (!req1_valid || (last_q == 1'b1));
        grant1_s     = req1_valid && (!req0_valid || (last_q == 1'b0));
        if (rst) begin
            req0_ready = 1'b0;
            req1_ready = 1'b0;
        end else begin
            req0_ready = grant0_s && can_accept_s;
            req1_ready = grant1_s && can_accept_s;
        end
        accept_s = req0_ready || req1_ready;
    end

    // Select the operands and run the single shifter. op[0] chooses the right-shift path.
    always_comb begin
        if (grant1_s) begin
            op_a_s    = req1_a;
            op_b_s    = req1_b;
            op_code_s = req1_op;
        end else begin
            op_a_s    = req0_a;
            op_b_s    = req0_b;
            op_code_s = req0_op;
        end
        sh_in_s  = op_code_s[0] ? rev32(op_a_s) : op_a_s;
        sh_out_s = shl32(sh_in_s, op_b_s);
        case (op_code_s)
            2'b01:   result_s = rev32(sh_out_s);
            2'b11:   result_s = rev32(sh_out_s) | (op_a_s[31] ? fill32(op_b_s) : 32'h0000_0000);
            default: result_s = sh_out_s;
        endcase
    end

    // Compute the next state of the response FSM, the response payload and the round-robin pointer.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        id_d    = id_q;
        s_d     = s_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept_s) begin
                    state_d = ST_FULL;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (accept_s) begin
                    state_d = ST_FULL;
                end else if (rsp_ready) begin
                    state_d = ST_EMPTY;
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (accept_s) begin
            last_d = req1_ready;
            id_d   = req1_ready;
            s_d    = result_s;
        end else begin
            last_d = last_q;
        end
    end

    // State registers with synchronous reset. Reset discards any held result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            last_q  <= LAST_INIT;
            id_q    <= 1'b0;
            s_q     <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            s_q     <= s_d;
        end
    end

    assign rsp_valid = (state_q == ST_FULL);
    assign rsp_id    = id_q;
    assign rsp_s     = s_q;

endmodule
